simd_lane_sequencer: RTL and testbench

Issue-side controller between the decode stage (opcode plus the 32-bit immediate from the immediate generator) and the shared vector execution lane. Scalar instructions take one beat. Vector instructions (opcode MSB set) are serialized into LANES beats, one lane per beat, over a valid/ready handshake. The block back-pressures decode while busy, pulses completion, and supports a synchronous pipeline flush.

---
 rtl/simd_lane_sequencer.sv | 120 ++++++++++++
 tb/tb_simd_lane_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/simd_lane_sequencer.sv
// simd_lane_sequencer: issues decoded instructions to the shared vector lane.
// Scalar opcodes take a single beat; vector opcodes (opcode MSB set) are
// serialized into LANES beats, one lane index per beat. Decode is
// back-pressured while an instruction is in flight, and completion is
// reported with a registered one-cycle pulse.
module simd_lane_sequencer #(
  parameter int LANES = 4,
  parameter int IDXW  = $clog2(LANES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [0:4]      in_opcode,
  input  logic [31:0]     in_imm,
  input  logic [4:0]      in_rd,
  output logic            lane_valid,
  input  logic            lane_ready,
  output logic [0:4]      lane_op,
  output logic [31:0]     lane_imm,
  output logic [4:0]      lane_rd,
  output logic [IDXW-1:0] lane_idx,
  output logic            lane_last,
  output logic            done,
  output logic            stall
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST_VEC = IDXW'(LANES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] w_idx_nxt;
  logic [IDXW-1:0] r_last_idx;
  logic [0:4]      r_op;
  logic [31:0]     r_imm;
  logic [4:0]      r_rd;
  logic            r_done;
  logic            w_done_nxt;
  logic            w_last;
  logic            w_fire;
  logic            w_ready;
  logic            w_accept;

  // The final beat is recognised from registered state only; in IDLE no beat
  // is presented, so lane_last stays low there.
  assign w_last   = (r_state == S_RUN) && (r_idx == r_last_idx);
  assign w_fire   = (r_state == S_RUN) && lane_ready;
  // Accepting during the final handshake gives back-to-back issue without a
  // bubble, at the cost of a combinational path from lane_ready.
  assign w_ready  = !rst && !flush && ((r_state == S_IDLE) || (w_fire && w_last));
  assign w_accept = in_valid && w_ready;

  // Next-state, next lane index and completion pulse; flush overrides both
  // completion and accept, and a flushed final beat never reports done.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
    end else begin
      if (w_fire) begin
        if (w_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDXW'(1);
        end
      end
      if (w_accept) begin
        w_state_nxt = S_RUN;
        w_idx_nxt   = '0;
      end
    end
  end

  // State, lane index and done pulse registers plus the latched instruction
  // fields, which only change when a new instruction is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_done     <= 1'b0;
      r_op       <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_op       <= in_opcode;
        r_imm      <= in_imm;
        r_rd       <= in_rd;
        r_last_idx <= in_opcode[0] ? LAST_VEC : '0;
      end
    end
  end

  assign in_ready   = w_ready;
  assign stall      = in_valid && !w_ready;
  assign lane_valid = (r_state == S_RUN);
  assign lane_op    = r_op;
  assign lane_imm   = r_imm;
  assign lane_rd    = r_rd;
  assign lane_idx   = r_idx;
  assign lane_last  = w_last;
  assign done       = r_done;

endmodule

// File: tb/tb_simd_lane_sequencer.sv
// Directed bench for simd_lane_sequencer with LANES=4.
module tb_simd_lane_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [0:4]  in_opcode;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic        lane_valid;
  logic        lane_ready;
  logic [0:4]  lane_op;
  logic [31:0] lane_imm;
  logic [4:0]  lane_rd;
  logic [1:0]  lane_idx;
  logic        lane_last;
  logic        done;
  logic        stall;

  int n_total = 0;
  int n_pass  = 0;

  simd_lane_sequencer #(.LANES(4), .IDXW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_imm     (in_imm),
    .in_rd      (in_rd),
    .lane_valid (lane_valid),
    .lane_ready (lane_ready),
    .lane_op    (lane_op),
    .lane_imm   (lane_imm),
    .lane_rd    (lane_rd),
    .lane_idx   (lane_idx),
    .lane_last  (lane_last),
    .done       (done),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are then driven 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check the beat currently presented to the lane.
  task automatic chk_beat(input string tag, input logic [1:0] idx, input logic last,
                          input logic [4:0] op, input logic [31:0] imm, input logic [4:0] rd);
    chk({tag, ".valid"}, 64'(lane_valid), 64'd1);
    chk({tag, ".idx"},   64'(lane_idx),   64'(idx));
    chk({tag, ".last"},  64'(lane_last),  64'(last));
    chk({tag, ".op"},    64'(lane_op),    64'(op));
    chk({tag, ".imm"},   64'(lane_imm),   64'(imm));
    chk({tag, ".rd"},    64'(lane_rd),    64'(rd));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1;
    in_opcode = 5'b00000; in_imm = 32'h0; in_rd = 5'd0; lane_ready = 1'b0;

    // ---------------- reset held 3 cycles with in_valid=1 ----------------
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rst.in_ready", 64'(in_ready), 64'd0);
      chk("rst.stall", 64'(stall), 64'd1);
      chk("rst.lane_valid", 64'(lane_valid), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.idx", 64'(lane_idx), 64'd0);
      chk("rst.last", 64'(lane_last), 64'd0);
      chk("rst.imm", 64'(lane_imm), 64'd0);
      chk("rst.op", 64'(lane_op), 64'd0);
    end
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("idle.in_ready", 64'(in_ready), 64'd1);
    chk("idle.stall", 64'(stall), 64'd0);

    // ---------------- vector 11001, imm 0x1F, lane_ready=1 ----------------
    in_valid = 1'b1; in_opcode = 5'b11001; in_imm = 32'h0000_001F; in_rd = 5'd7;
    lane_ready = 1'b1; #1;
    chk("vec.accept_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_beat("vec.beat", 2'(i), (i == 3), 5'b11001, 32'h1F, 5'd7);
      chk("vec.done_early", 64'(done), 64'd0);
      tick();
    end
    #1;
    chk("vec.done", 64'(done), 64'd1);
    chk("vec.idle_valid", 64'(lane_valid), 64'd0);
    tick(); #1;
    chk("vec.done_one_cycle", 64'(done), 64'd0);

    // ---------------- scalar 01000 then vector 10011 back-to-back ----------------
    in_valid = 1'b1; in_opcode = 5'b01000; in_imm = 32'h55; in_rd = 5'd3; #1;
    tick();
    in_opcode = 5'b10011; in_imm = 32'hAA; in_rd = 5'd9; #1;
    chk_beat("b2b.scalar", 2'd0, 1'b1, 5'b01000, 32'h55, 5'd3);
    chk("b2b.in_ready_last", 64'(in_ready), 64'd1);
    chk("b2b.stall", 64'(stall), 64'd0);
    chk("b2b.scalar_done_early", 64'(done), 64'd0);
    tick();
    in_valid = 1'b0; #1;
    chk_beat("b2b.vec0", 2'd0, 1'b0, 5'b10011, 32'hAA, 5'd9);
    chk("b2b.scalar_done", 64'(done), 64'd1);
    tick(); #1;
    chk_beat("b2b.vec1", 2'd1, 1'b0, 5'b10011, 32'hAA, 5'd9);
    chk("b2b.done_cleared", 64'(done), 64'd0);
    tick(); tick(); #1;
    chk_beat("b2b.vec3", 2'd3, 1'b1, 5'b10011, 32'hAA, 5'd9);
    tick(); #1;
    chk("b2b.vec_done", 64'(done), 64'd1);
    chk("b2b.idle", 64'(lane_valid), 64'd0);

    // ---------------- backpressure: 3 stall cycles at idx 2 ----------------
    in_valid = 1'b1; in_opcode = 5'b10010; in_imm = 32'h1234_5678; in_rd = 5'd17; #1;
    tick();                                 // accepted; idx0 now presented
    in_valid = 1'b0;
    tick(); tick();                         // idx2 presented
    lane_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 5'b00001; in_imm = 32'hFFFF_0000; in_rd = 5'd30;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_beat("bp.hold", 2'd2, 1'b0, 5'b10010, 32'h1234_5678, 5'd17);
      chk("bp.stall", 64'(stall), 64'd1);
      chk("bp.in_ready", 64'(in_ready), 64'd0);
      chk("bp.done", 64'(done), 64'd0);
      tick();
    end
    lane_ready = 1'b1; in_valid = 1'b0; #1;
    chk_beat("bp.release", 2'd2, 1'b0, 5'b10010, 32'h1234_5678, 5'd17);
    tick(); #1;
    chk_beat("bp.idx3", 2'd3, 1'b1, 5'b10010, 32'h1234_5678, 5'd17);
    chk("bp.done_pre", 64'(done), 64'd0);
    tick(); #1;
    chk("bp.done", 64'(done), 64'd1);

    // ---------------- flush at idx 1 ----------------
    in_valid = 1'b1; in_opcode = 5'b11111; in_imm = 32'h0000_DEAD; in_rd = 5'd1; #1;
    tick();
    in_valid = 1'b0;
    tick(); #1;
    chk_beat("fl.idx1", 2'd1, 1'b0, 5'b11111, 32'hDEAD, 5'd1);
    flush = 1'b1;
    in_valid = 1'b1; in_opcode = 5'b10001; in_imm = 32'h0000_BEEF; in_rd = 5'd2; #1;
    chk("fl.in_ready", 64'(in_ready), 64'd0);
    chk("fl.stall", 64'(stall), 64'd1);
    tick();
    flush = 1'b0; #1;
    chk("fl.lane_valid", 64'(lane_valid), 64'd0);
    chk("fl.done", 64'(done), 64'd0);
    chk("fl.idx", 64'(lane_idx), 64'd0);
    chk("fl.in_ready_after", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; #1;
    chk_beat("fl.new0", 2'd0, 1'b0, 5'b10001, 32'hBEEF, 5'd2);
    chk("fl.no_done", 64'(done), 64'd0);
    tick(); tick(); tick(); #1;
    chk_beat("fl.new3", 2'd3, 1'b1, 5'b10001, 32'hBEEF, 5'd2);
    tick(); #1;
    chk("fl.new_done", 64'(done), 64'd1);

    // ---------------- reset at idx 2 ----------------
    in_valid = 1'b1; in_opcode = 5'b10101; in_imm = 32'h77; in_rd = 5'd4; #1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); #1;
    chk_beat("mr.idx2", 2'd2, 1'b0, 5'b10101, 32'h77, 5'd4);
    rst = 1'b1;
    tick(); #1;
    chk("mr.lane_valid", 64'(lane_valid), 64'd0);
    chk("mr.idx", 64'(lane_idx), 64'd0);
    chk("mr.last", 64'(lane_last), 64'd0);
    chk("mr.op", 64'(lane_op), 64'd0);
    chk("mr.imm", 64'(lane_imm), 64'd0);
    chk("mr.rd", 64'(lane_rd), 64'd0);
    chk("mr.done", 64'(done), 64'd0);
    chk("mr.in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick(); #1;
    chk("mr.no_done", 64'(done), 64'd0);
    chk("mr.idle", 64'(lane_valid), 64'd0);
    chk("mr.ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
